// File: rtl/mmss_pkg.sv
// Shared types and constants for the MM:SS stopwatch counter.
package mmss_pkg;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        PAUSED = 2'd1,
        ADJUST = 2'd2
    } state_e;

    localparam int ONES_MAX         = 9;
    localparam int SEC_TENS_MAX_DEF = 5;
    localparam int MIN_TENS_MAX_DEF = 5;

    localparam logic [3:0] BLANK_NONE = 4'b0000;
    localparam logic [3:0] BLANK_SEC  = 4'b0011;
    localparam logic [3:0] BLANK_MIN  = 4'b1100;

endpackage

// File: rtl/bcd_mod60_field.sv
// Two-digit BCD field counter (ones 0-9, tens 0-tens_max) with combinational carry-out.
module bcd_mod60_field
    import mmss_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       inc,
    input  logic [2:0] tens_max,
    output logic [3:0] ones,
    output logic [2:0] tens,
    output logic       carry
);

    logic [3:0] ones_q, ones_d;
    logic [2:0] tens_q, tens_d;
    logic       at_max;
    logic       illegal;

    assign at_max  = (ones_q == 4'(ONES_MAX)) && (tens_q == tens_max);
    // Out-of-range contents restart from zero instead of counting onward.
    assign illegal = (ones_q > 4'(ONES_MAX)) || (tens_q > tens_max);
    assign carry   = inc && at_max;

    always_comb begin
        ones_d = ones_q;
        tens_d = tens_q;
        if (inc) begin
            if (at_max || illegal) begin
                ones_d = 4'd0;
                tens_d = 3'd0;
            end else if (ones_q == 4'(ONES_MAX)) begin
                ones_d = 4'd0;
                tens_d = tens_q + 3'd1;
            end else begin
                ones_d = ones_q + 4'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ones_q <= 4'd0;
            tens_q <= 3'd0;
        end else begin
            ones_q <= ones_d;
            tens_q <= tens_d;
        end
    end

    assign ones = ones_q;
    assign tens = tens_q;

endmodule

// File: rtl/mmss_time_counter.sv
// MM:SS stopwatch: counts on 1 Hz ticks, pause/resume, per-field adjust on 2 Hz ticks.
//   state  | meaning
//   RUN    | digits advance on tick_run
//   PAUSED | digits hold, waiting for pause_tgl
//   ADJUST | selected field advances on tick_adj, blink phase drives blank
module mmss_time_counter
    import mmss_pkg::*;
#(
    parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEF,
    parameter int MIN_TENS_MAX = MIN_TENS_MAX_DEF
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tick_run,
    input  logic       tick_adj,
    input  logic       pause_tgl,
    input  logic       adj,
    input  logic       sel,
    output logic [3:0] sec0,
    output logic [2:0] sec1,
    output logic [3:0] min0,
    output logic [2:0] min1,
    output logic [3:0] blank,
    output logic       paused,
    output logic       wrap
);

    state_e     state_q;
    logic       pflag_q;
    logic       blink_q, blink_d;
    logic [3:0] blank_q;
    logic       wrap_q;

    logic       run_inc, adj_inc;
    logic       sec_inc, min_inc;
    logic       sec_carry, min_carry;

    // adj has priority over tick_run in the cycle it first reads high.
    assign run_inc = (state_q == RUN) && !adj && tick_run;
    assign adj_inc = (state_q == ADJUST) && adj && tick_adj;
    assign sec_inc = run_inc || (adj_inc && !sel);
    assign min_inc = (run_inc && sec_carry) || (adj_inc && sel);

    // Blink phase only survives while staying in ADJUST.
    assign blink_d = (state_q == ADJUST && adj) ? (blink_q ^ tick_adj) : 1'b0;

    bcd_mod60_field u_sec (
        .clk      (clk),
        .rst      (rst),
        .inc      (sec_inc),
        .tens_max (3'(SEC_TENS_MAX)),
        .ones     (sec0),
        .tens     (sec1),
        .carry    (sec_carry)
    );

    bcd_mod60_field u_min (
        .clk      (clk),
        .rst      (rst),
        .inc      (min_inc),
        .tens_max (3'(MIN_TENS_MAX)),
        .ones     (min0),
        .tens     (min1),
        .carry    (min_carry)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= RUN;
            pflag_q <= 1'b0;
            blink_q <= 1'b0;
            blank_q <= BLANK_NONE;
            wrap_q  <= 1'b0;
        end else begin
            wrap_q  <= run_inc && min_carry;
            blink_q <= blink_d;
            blank_q <= (adj && blink_d) ? (sel ? BLANK_MIN : BLANK_SEC) : BLANK_NONE;
            case (state_q)
                RUN, PAUSED: begin
                    if (adj) begin
                        state_q <= ADJUST;
                    end else if (pause_tgl) begin
                        state_q <= (state_q == RUN) ? PAUSED : RUN;
                        pflag_q <= ~pflag_q;
                    end
                end
                ADJUST: begin
                    if (!adj) begin
                        state_q <= pflag_q ? PAUSED : RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign blank  = blank_q;
    assign paused = pflag_q;
    assign wrap   = wrap_q;

endmodule

// File: tb/tb_mmss_time_counter.sv
// Self-checking bench for mmss_time_counter: directed plan steps plus a randomized run.
module tb_mmss_time_counter;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       tick_run = 1'b0, tick_adj = 1'b0, pause_tgl = 1'b0, adj = 1'b0, sel = 1'b0;
    logic [3:0] sec0, min0, blank;
    logic [2:0] sec1, min1;
    logic       paused, wrap;

    int checks = 0;
    int failures = 0;

    // Reference model: whole minutes/seconds plus mode flags.
    int         m_mm, m_ss;
    bit         m_adj, m_pflag, m_blink, m_wrap;
    logic [3:0] m_blank;

    always #5 clk = ~clk;

    mmss_time_counter dut (
        .clk       (clk),
        .rst       (rst),
        .tick_run  (tick_run),
        .tick_adj  (tick_adj),
        .pause_tgl (pause_tgl),
        .adj       (adj),
        .sel       (sel),
        .sec0      (sec0),
        .sec1      (sec1),
        .min0      (min0),
        .min1      (min1),
        .blank     (blank),
        .paused    (paused),
        .wrap      (wrap)
    );

    task automatic model_reset();
        m_mm = 0; m_ss = 0;
        m_adj = 0; m_pflag = 0; m_blink = 0; m_wrap = 0;
        m_blank = 4'b0000;
    endtask

    task automatic model_edge(input bit tr, input bit ta, input bit pt, input bit a, input bit s);
        int t;
        m_wrap = 0;
        if (!m_adj) begin
            if (a) begin
                m_adj = 1;
            end else begin
                if (!m_pflag && tr) begin
                    t = m_mm * 60 + m_ss + 1;
                    if (t == 3600) m_wrap = 1;
                    t = t % 3600;
                    m_mm = t / 60;
                    m_ss = t % 60;
                end
                if (pt) m_pflag = !m_pflag;
            end
        end else if (a) begin
            if (ta) begin
                if (s) m_mm = (m_mm + 1) % 60;
                else   m_ss = (m_ss + 1) % 60;
                m_blink = !m_blink;
            end
        end else begin
            m_adj = 0;
            m_blink = 0;
        end
        m_blank = (m_adj && m_blink) ? (s ? 4'b1100 : 4'b0011) : 4'b0000;
    endtask

    task automatic check_all(input string tag);
        logic [19:0] obs, exp;
        obs = {min1, min0, sec1, sec0, blank, paused, wrap};
        exp = {3'(m_mm / 10), 4'(m_mm % 10), 3'(m_ss / 10), 4'(m_ss % 10), m_blank, m_pflag, m_wrap};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed {mm,ss,blank,paused,wrap}=%h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_time(input string tag, input int mm, input int ss);
        logic [13:0] obs, exp;
        obs = {min1, min0, sec1, sec0};
        exp = {3'(mm / 10), 4'(mm % 10), 3'(ss / 10), 4'(ss % 10)};
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed time=%h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Called at a negedge: drive, let one posedge happen, check at the following negedge.
    task automatic step(input string tag, input bit tr, input bit ta, input bit pt, input bit a, input bit s);
        tick_run = tr; tick_adj = ta; pause_tgl = pt; adj = a; sel = s;
        @(posedge clk);
        model_edge(tr, ta, pt, a, s);
        @(negedge clk);
        tick_run = 0; tick_adj = 0; pause_tgl = 0;
        check_all(tag);
    endtask

    task automatic run_ticks(input string tag, input int n);
        for (int i = 0; i < n; i++) step(tag, 1, 0, 0, 0, 0);
    endtask

    task automatic mid_cycle_reset(input string tag);
        #2 rst = 1'b0;
        model_reset();
        #1 check_all({tag, "_async"});
        @(negedge clk);
        check_all({tag, "_held"});
        rst = 1'b1;
    endtask

    initial begin
        bit r_adj, r_sel;
        model_reset();
        #2 rst = 1'b0;
        #1 check_all("reset");
        @(negedge clk);
        rst = 1'b1;

        // 1: 61 ticks -> 01:01
        run_ticks("t1_count", 61);
        check_time("t1_0101", 1, 1);

        // 2: to 59:59, then roll over with a one-cycle wrap
        run_ticks("t2_preload", 3599 - 61);
        check_time("t2_5959", 59, 59);
        step("t2_roll", 1, 0, 0, 0, 0);
        check_time("t2_0000", 0, 0);
        check_bit("t2_wrap_hi", wrap, 1'b1);
        step("t2_idle", 0, 0, 0, 0, 0);
        check_bit("t2_wrap_lo", wrap, 1'b0);

        // 3: pause holds, resume continues
        run_ticks("t3_to5", 5);
        step("t3_pause", 0, 0, 1, 0, 0);
        run_ticks("t3_held", 10);
        check_time("t3_0005", 0, 5);
        check_bit("t3_paused", paused, 1'b1);
        step("t3_resume", 0, 0, 1, 0, 0);
        run_ticks("t3_tick", 1);
        check_time("t3_0006", 0, 6);
        check_bit("t3_running", paused, 1'b0);

        // 4: adjust seconds 58 -> 01, blink alternates, tick_run ignored
        run_ticks("t4_to58", 52);
        step("t4_enter", 1, 0, 0, 1, 0);
        check_time("t4_no_inc", 0, 58);
        step("t4_adj1", 0, 1, 0, 1, 0);
        check_bit("t4_blank_on", blank == 4'b0011, 1'b1);
        step("t4_run_ign", 1, 0, 0, 1, 0);
        step("t4_adj2", 0, 1, 0, 1, 0);
        check_bit("t4_blank_off", blank == 4'b0000, 1'b1);
        step("t4_adj3", 0, 1, 0, 1, 0);
        check_time("t4_0001", 0, 1);
        step("t4_exit", 0, 1, 0, 0, 0);

        // 5: adjust minutes while paused, return to PAUSED
        run_ticks("t5_to1234", 753);
        check_time("t5_1234", 12, 34);
        step("t5_pause", 0, 0, 1, 0, 0);
        step("t5_enter", 0, 0, 0, 1, 1);
        step("t5_adj1", 0, 1, 0, 1, 1);
        check_bit("t5_blank_min", blank == 4'b1100, 1'b1);
        step("t5_adj2", 0, 1, 0, 1, 1);
        step("t5_exit", 0, 0, 0, 0, 1);
        check_time("t5_1434", 14, 34);
        check_bit("t5_paused", paused, 1'b1);
        step("t5_run_ign", 1, 0, 0, 0, 0);
        check_time("t5_hold", 14, 34);

        // 6: async reset with adj held high, ADJUST right after release
        mid_cycle_reset("t6_clear");
        run_ticks("t6_to0321", 201);
        check_time("t6_0321", 3, 21);
        step("t6_adj_on", 0, 0, 0, 1, 0);
        mid_cycle_reset("t6_rst");
        check_bit("t6_paused0", paused, 1'b0);
        step("t6_reenter", 1, 0, 0, 1, 0);
        step("t6_adj_tick", 0, 1, 0, 1, 0);
        check_time("t6_0001", 0, 1);
        check_bit("t6_blank", blank == 4'b0011, 1'b1);
        step("t6_exit", 0, 0, 0, 0, 0);

        // Randomized run against the model
        r_adj = 0; r_sel = 0;
        for (int i = 0; i < 2500; i++) begin
            if ($urandom_range(0, 39) == 0) r_adj = !r_adj;
            if ($urandom_range(0, 7) == 0)  r_sel = !r_sel;
            step("rand",
                 $urandom_range(0, 2) == 0,
                 $urandom_range(0, 3) == 0,
                 $urandom_range(0, 15) == 0,
                 r_adj, r_sel);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
